ascii_scroll_display: RTL and testbench

Parametrised successor to the team's single-digit ASCII-to-7-segment decoder. The block buffers an ASCII string written one character per clock and drives NUM_DIGITS seven-segment digits from it. It supports a static left-aligned mode and a timed scrolling marquee mode. It sits between the lab FSM/top level (character source) and the board HEX outputs.

---
 rtl/ascii_scroll_display.sv | 128 ++++++++++++
 tb/tb_ascii_scroll_display.sv | 117 +++++++++++
 2 files changed

// File: rtl/ascii_scroll_display.sv
// ascii_scroll_display: buffered ASCII string shown on NUM_DIGITS 7-seg digits, static or scrolling
module ascii_scroll_display #(
  parameter int NUM_DIGITS = 6,
  parameter int BUF_DEPTH = 16,
  parameter int TICK_DIV = 25000000,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [7:0]              wr_char,
  input  logic                    clear,
  input  logic                    mode,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    overflow
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int IW = $clog2(BUF_DEPTH + 2*NUM_DIGITS + 1);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [7:0] mem_q [BUF_DEPTH];
  logic [7:0] mem_d [BUF_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] s_q, s_d, len;
  logic [TW-1:0] tick_q, tick_d;
  logic ovf_q, ovf_d, mode_q, we, run, wrap;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  function automatic logic [6:0] glyph(input logic [7:0] ch);
    logic [7:0] u;
    u = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    case (u)
      "0": glyph = 7'b1000000;
      "1": glyph = 7'b1111001;
      "2": glyph = 7'b0100100;
      "3": glyph = 7'b0110000;
      "4": glyph = 7'b0011001;
      "5": glyph = 7'b0010010;
      "6": glyph = 7'b0000010;
      "7": glyph = 7'b1111000;
      "8": glyph = 7'b0000000;
      "9": glyph = 7'b0010000;
      "A": glyph = 7'b0001000;
      "B": glyph = 7'b0000011;
      "C": glyph = 7'b1000110;
      "D": glyph = 7'b0100001;
      "E": glyph = 7'b0000110;
      "F": glyph = 7'b0001110;
      "G": glyph = 7'b1000010;
      "H": glyph = 7'b0001001;
      "I": glyph = 7'b1111001;
      "J": glyph = 7'b1100001;
      "K": glyph = 7'b0001010;
      "L": glyph = 7'b1000111;
      "M": glyph = 7'b1001000;
      "N": glyph = 7'b0101011;
      "O": glyph = 7'b1000000;
      "P": glyph = 7'b0001100;
      "Q": glyph = 7'b0011000;
      "R": glyph = 7'b0101111;
      "S": glyph = 7'b0010010;
      "T": glyph = 7'b0000111;
      "U": glyph = 7'b1000001;
      "V": glyph = 7'b1100011;
      "W": glyph = 7'b1010101;
      "X": glyph = 7'b0001001;
      "Y": glyph = 7'b0010001;
      "Z": glyph = 7'b0100100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign full = count_q == CW'(BUF_DEPTH);
  assign len = IW'(count_q) + IW'(NUM_DIGITS);

  // buffer write, counters, window step; clear beats write, mode edge restarts the marquee
  always_comb begin
    mem_d = mem_q;
    we = wr_en && !full && !clear;
    if (we) mem_d[count_q[AW-1:0]] = wr_char;
    count_d = clear ? '0 : we ? count_q + CW'(1) : count_q;
    ovf_d = clear ? 1'b0 : (wr_en && full) ? 1'b1 : ovf_q;
    run = mode && mode_q && count_q != '0 && !clear;
    wrap = tick_q == TW'(TICK_DIV - 1);
    tick_d = (!run || wrap) ? '0 : tick_q + TW'(1);
    s_d = !run ? '0 : !wrap ? s_q : (s_q + IW'(1) == len) ? '0 : s_q + IW'(1);
  end

  // digit d shows seq[(s + NUM_DIGITS-1-d) mod L]; positions past count are blank
  always_comb begin
    logic [IW-1:0] raw, idx;
    hex_d = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      raw = s_q + IW'(NUM_DIGITS - 1 - d);
      idx = raw >= len ? raw - len : raw;
      hex_d[7*d +: 7] = idx < IW'(count_q) ? glyph(mem_q[idx[AW-1:0]]) : 7'h7f;
    end
  end

  // control state and registered display, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      s_q <= '0;
      tick_q <= '0;
      ovf_q <= 1'b0;
      mode_q <= 1'b0;
      hex_q <= '1;
    end else begin
      count_q <= count_d;
      s_q <= s_d;
      tick_q <= tick_d;
      ovf_q <= ovf_d;
      mode_q <= mode;
      hex_q <= hex_d;
    end
  end

  // character storage needs no reset since count masks stale entries
  always_ff @(posedge clk) begin
    if (rst_n) mem_q <= mem_d;
  end

  assign hex_segs = hex_q;
  assign count = count_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ascii_scroll_display.sv
// tb_ascii_scroll_display: directed checks of static, scroll, overflow, clear and reset behaviour
module tb_ascii_scroll_display;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] G1 = 7'b1111001;
  logic clk = 0, rst_n = 0, wr_en = 1, clear = 0, mode = 0;
  logic [7:0] wr_char = "A";
  logic [41:0] hex_segs;
  logic [4:0] count;
  logic full, overflow;
  int n_chk = 0, n_fail = 0;

  ascii_scroll_display #(.NUM_DIGITS(6), .BUF_DEPTH(16), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_char(wr_char), .clear(clear),
    .mode(mode), .hex_segs(hex_segs), .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] c);
    wr_en = 1;
    wr_char = c;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    cyc(2);
    check("rst_hex", 64'(hex_segs), 64'({6{BL}}));
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    check("rst_ovf", 64'(overflow), 0);
    rst_n = 1;
    wr_en = 0;
    cyc(1);
    check("idle_count", 64'(count), 0);
    put("H"); put("e"); put("L"); put("L"); put("o");
    check("hello_count", 64'(count), 5);
    cyc(1);
    check("hello_hex", 64'(hex_segs),
          64'({7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111, 7'b1000000, BL}));
    pulse_clear();
    put("A"); put("1");
    cyc(1);
    mode = 1;
    cyc(2);
    check("scroll_s0", 64'(hex_segs), 64'({GA, G1, {4{BL}}}));
    cyc(5);
    check("scroll_s1", 64'(hex_segs), 64'({G1, {5{BL}}}));
    cyc(4);
    check("scroll_s2", 64'(hex_segs), 64'({6{BL}}));
    cyc(4);
    check("scroll_s3", 64'(hex_segs), 64'({{5{BL}}, GA}));
    cyc(16);
    check("scroll_s7", 64'(hex_segs), 64'({BL, GA, G1, {3{BL}}}));
    cyc(4);
    check("scroll_wrap", 64'(hex_segs), 64'({GA, G1, {4{BL}}}));
    cyc(11);
    check("pre_rst_s3", 64'(hex_segs), 64'({{5{BL}}, GA}));
    rst_n = 0;
    cyc(1);
    check("midrst_hex", 64'(hex_segs), 64'({6{BL}}));
    check("midrst_count", 64'(count), 0);
    rst_n = 1;
    mode = 0;
    put("8");
    cyc(1);
    check("eight_hex", 64'(hex_segs), 64'({7'b0000000, {5{BL}}}));
    pulse_clear();
    for (int i = 0; i < 16; i++) put(8'h41 + 8'(i));
    check("fill_full", 64'(full), 1);
    check("fill_ovf", 64'(overflow), 0);
    put("Z");
    check("ovf_count", 64'(count), 16);
    check("ovf_full", 64'(full), 1);
    check("ovf_flag", 64'(overflow), 1);
    check("ovf_hex", 64'(hex_segs),
          64'({GA, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}));
    pulse_clear();
    check("clr_count", 64'(count), 0);
    check("clr_ovf", 64'(overflow), 0);
    check("clr_full", 64'(full), 0);
    cyc(1);
    check("clr_hex", 64'(hex_segs), 64'({6{BL}}));
    put("H");
    clear = 1;
    put("Z");
    clear = 0;
    check("clrwr_count", 64'(count), 0);
    cyc(1);
    check("clrwr_hex", 64'(hex_segs), 64'({6{BL}}));
    put(8'h21); put("A");
    check("bang_count", 64'(count), 2);
    cyc(1);
    check("bang_hex", 64'(hex_segs), 64'({BL, GA, {4{BL}}}));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
